// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Constants and state encoding shared by the FP iterative
//               divide / square-root unit and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF   = 32'h7F80_0000;
    localparam int          EXP_BIAS  = 127;
    localparam logic [4:0]  ITER_DIV  = 5'd25;   // quotient bits produced
    localparam logic [4:0]  ITER_SQRT = 5'd24;   // root bits produced

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        NORM = 2'd2
    } state_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify
// Description : Combinational IEEE-754 single-precision operand classifier.
//               Denormals are reported as zero.
// Ports       : i_x        operand
//               o_is_zero  exponent field is zero (zero or flushed denormal)
//               o_is_inf   infinity
//               o_is_nan   any NaN
//               o_sign     sign bit
// Revision    : 1.0 - initial release
// ============================================================================
module fp_classify (
    input  logic [31:0] i_x,
    output logic        o_is_zero,
    output logic        o_is_inf,
    output logic        o_is_nan,
    output logic        o_sign
);

    logic w_exp_max;
    logic w_man_zero;

    assign w_exp_max  = (i_x[30:23] == 8'hFF);
    assign w_man_zero = (i_x[22:0] == 23'd0);

    assign o_is_zero  = (i_x[30:23] == 8'h00);
    assign o_is_inf   = w_exp_max &  w_man_zero;
    assign o_is_nan   = w_exp_max & ~w_man_zero;
    assign o_sign     = i_x[31];

endmodule : fp_classify
`default_nettype wire

// File: rtl/fp_divsqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_divsqrt_iter
// Description : Iterative single-precision divide / square root. Radix-2
//               restoring division and digit-by-digit square root, one bit
//               per cycle, truncating result, denormals treated as zero.
// Ports       : clk, clr        clock, synchronous active-high clear
//               start, op       request (op 0 = a/b, 1 = sqrt(a))
//               a, b, rd_in     operands and destination tag
//               busy            op in flight (pipeline stall)
//               done            one-cycle result-valid pulse
//               result, rd_out  result and its destination tag
//               cnt             iterations remaining
// Revision    : 1.0 - initial release
// ============================================================================
module fp_divsqrt_iter
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic [4:0]  cnt
);

    state_t      r_state;
    logic        r_op;
    logic        r_sign;
    logic [9:0]  r_exp;       // signed biased exponent before normalisation
    logic [25:0] r_rem;       // shared partial remainder
    logic [24:0] r_q;         // quotient / root bits, shifted in from LSB
    logic [47:0] r_rad;       // radicand, consumed two bits per step
    logic [23:0] r_mb;        // divisor mantissa with hidden one
    logic [4:0]  r_rd;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;

    logic w_za, w_ia, w_na, w_sa;
    logic w_zb, w_ib, w_nb, w_sb;

    fp_classify u_cls_a (.i_x(a), .o_is_zero(w_za), .o_is_inf(w_ia), .o_is_nan(w_na), .o_sign(w_sa));
    fp_classify u_cls_b (.i_x(b), .o_is_zero(w_zb), .o_is_inf(w_ib), .o_is_nan(w_nb), .o_sign(w_sb));

    // ---------------- acceptance-time decode ----------------
    logic        w_sign_div;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic [23:0] w_ma;
    logic [47:0] w_rad;
    logic [9:0]  w_exp_div;
    logic [9:0]  w_exp_sqrt;

    assign w_sign_div = w_sa ^ w_sb;
    assign w_ma       = {1'b1, a[22:0]};
    // Odd biased exponent means an even unbiased one: shift one less so the
    // radicand keeps an even power of two and the root lands in [2^23, 2^24).
    assign w_rad      = a[23] ? {1'b0, w_ma, 23'd0} : {w_ma, 24'd0};
    assign w_exp_div  = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(EXP_BIAS);
    assign w_exp_sqrt = ({2'b00, a[30:23]} + 10'(EXP_BIAS)) >> 1;

    always_comb begin
        w_special  = 1'b0;
        w_spec_res = 32'd0;
        if (!op) begin
            if (w_na | w_nb | (w_za & w_zb) | (w_ia & w_ib)) begin
                w_special  = 1'b1;
                w_spec_res = FP_QNAN;
            end else if (w_ia | w_zb) begin
                w_special  = 1'b1;
                w_spec_res = FP_PINF | {w_sign_div, 31'd0};
            end else if (w_za | w_ib) begin
                w_special  = 1'b1;
                w_spec_res = {w_sign_div, 31'd0};
            end
        end else begin
            if (w_na) begin
                w_special  = 1'b1;
                w_spec_res = FP_QNAN;
            end else if (w_za) begin
                w_special  = 1'b1;
                w_spec_res = {w_sa, 31'd0};
            end else if (w_sa) begin
                w_special  = 1'b1;
                w_spec_res = FP_QNAN;
            end else if (w_ia) begin
                w_special  = 1'b1;
                w_spec_res = FP_PINF;
            end
        end
    end

    // ---------------- shared iteration datapath ----------------
    // Division compares the remainder against the divisor; square root brings
    // down two radicand bits and compares against (root << 2) | 1. Both feed
    // the same subtractor; the extra MSB of the difference is the borrow.
    logic [25:0] w_minuend;
    logic [25:0] w_subtr;
    logic [26:0] w_diff;
    logic        w_borrow;
    logic [25:0] w_keep;
    logic [25:0] w_rem_next;

    assign w_minuend  = r_op ? {r_rem[23:0], r_rad[47:46]} : r_rem;
    assign w_subtr    = r_op ? {r_q[23:0], 2'b01} : {2'b00, r_mb};
    assign w_diff     = {1'b0, w_minuend} - {1'b0, w_subtr};
    assign w_borrow   = w_diff[26];
    assign w_keep     = w_borrow ? w_minuend : w_diff[25:0];
    assign w_rem_next = r_op ? w_keep : {w_keep[24:0], 1'b0};

    // ---------------- normalisation ----------------
    logic signed [9:0] w_norm_exp;
    logic [22:0]       w_norm_man;
    logic [31:0]       w_norm_res;

    always_comb begin
        w_norm_exp = $signed(r_exp);
        w_norm_man = r_q[22:0];
        if (!r_op) begin
            if (r_q[24]) begin
                w_norm_man = r_q[23:1];
            end else begin
                w_norm_exp = $signed(r_exp) - 10'sd1;
            end
        end
        if (w_norm_exp >= 10'sd255) begin
            w_norm_res = FP_PINF | {r_sign, 31'd0};
        end else if (w_norm_exp <= 10'sd0) begin
            w_norm_res = {r_sign, 31'd0};
        end else begin
            w_norm_res = {r_sign, w_norm_exp[7:0], w_norm_man};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= IDLE;
            r_op     <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= 10'd0;
            r_rem    <= 26'd0;
            r_q      <= 25'd0;
            r_rad    <= 48'd0;
            r_mb     <= 24'd0;
            r_rd     <= 5'd0;
            r_cnt    <= 5'd0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
            r_rd_out <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_sign <= op ? w_sa : w_sign_div;
                        r_rd   <= rd_in;
                        if (w_special) begin
                            r_result <= w_spec_res;
                            r_rd_out <= rd_in;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= ITER;
                            r_cnt   <= op ? ITER_SQRT : ITER_DIV;
                            r_exp   <= op ? w_exp_sqrt : w_exp_div;
                            r_rem   <= op ? 26'd0 : {2'b00, w_ma};
                            r_q     <= 25'd0;
                            r_rad   <= w_rad;
                            r_mb    <= {1'b1, b[22:0]};
                        end
                    end
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[23:0], ~w_borrow};
                    r_rad <= {r_rad[45:0], 2'b00};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_result <= w_norm_res;
                    r_rd_out <= r_rd;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;
    assign rd_out = r_rd_out;
    assign cnt    = r_cnt;

endmodule : fp_divsqrt_iter
`default_nettype wire

// File: tb/tb_fp_divsqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_divsqrt_iter
// Description : Self-checking bench for fp_divsqrt_iter: directed table,
//               abort / busy / back-to-back sequences, and random operands
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_divsqrt_iter;

    logic        clk = 1'b0;
    logic        clr, start, op;
    logic [31:0] a, b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out, cnt;

    always #5 clk = ~clk;

    fp_divsqrt_iter dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result),
        .rd_out(rd_out), .cnt(cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // floor(sqrt(x)) by bisection
    function automatic longint isqrt(input longint x);
        longint lo, hi, mid;
        lo = 0;
        hi = 64'd1 << 25;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Reference: specials by rule, else exact integer arithmetic, truncated.
    function automatic void ref_model(input bit fop, input logic [31:0] fa, input logic [31:0] fb,
                                      output logic [31:0] r, output int lat);
        int     ea, eb, e;
        longint ma, mb, q, root;
        bit     za, zb, ia, ib, na, nb, s;
        logic [22:0] mant;
        ea = int'(fa[30:23]);
        eb = int'(fb[30:23]);
        za = (ea == 0);   zb = (eb == 0);
        ia = (ea == 255) && (fa[22:0] == 0);  na = (ea == 255) && (fa[22:0] != 0);
        ib = (eb == 255) && (fb[22:0] == 0);  nb = (eb == 255) && (fb[22:0] != 0);
        ma = longint'(fa[22:0]) + (64'd1 << 23);
        mb = longint'(fb[22:0]) + (64'd1 << 23);
        lat = 0;
        if (!fop) begin
            s = fa[31] ^ fb[31];
            if (na || nb || (za && zb) || (ia && ib)) r = 32'h7FC00000;
            else if (ia || zb) r = {s, 31'h7F800000};
            else if (za || ib) r = {s, 31'd0};
            else begin
                lat = 26;
                q = (ma << 24) / mb;
                e = ea - eb + 127;
                if (q >= (64'd1 << 24)) mant = 23'(q >> 1);
                else begin
                    mant = 23'(q);
                    e = e - 1;
                end
                if (e >= 255) r = {s, 31'h7F800000};
                else if (e <= 0) r = {s, 31'd0};
                else r = {s, 8'(e), mant};
            end
        end else begin
            if (na) r = 32'h7FC00000;
            else if (za) r = {fa[31], 31'd0};
            else if (fa[31]) r = 32'h7FC00000;
            else if (ia) r = 32'h7F800000;
            else begin
                lat = 25;
                root = isqrt((ea % 2 == 1) ? (ma << 23) : (ma << 24));
                r = {1'b0, 8'((ea + 127) / 2), 23'(root)};
            end
        end
    endfunction

    // Issue one op (inputs change at negedge) and wait up to 40 edges for done.
    // lat = edges after the acceptance edge before done is seen (-1 = never).
    task automatic do_op(input bit fop, input logic [31:0] fa, input logic [31:0] fb, input logic [4:0] frd,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat,
                         output int bcyc, output logic [4:0] cnt0, output logic b2b, output logic busy_dn);
        @(negedge clk);
        b2b = done;
        start = 1'b1; op = fop; a = fa; b = fb; rd_in = frd;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; bcyc = 0; res = 'x; rdo = 'x; cnt0 = cnt; busy_dn = 1'bx;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (done) begin
                lat = n; res = result; rdo = rd_out; busy_dn = busy;
                break;
            end
            if (busy) bcyc++;
        end
        n_vec++;
    endtask

    task automatic run_check(input string tag, input bit fop, input logic [31:0] fa, input logic [31:0] fb,
                             input logic [4:0] frd, input logic [31:0] eres, input int elat);
        logic [31:0] res;
        logic [4:0]  rdo, cnt0;
        int          lat, bcyc;
        logic        b2b, bdn;
        do_op(fop, fa, fb, frd, res, rdo, lat, bcyc, cnt0, b2b, bdn);
        check({tag, " result"}, res, eres);
        check({tag, " latency"}, lat, elat);
        check({tag, " busy cycles"}, bcyc, elat);
        check({tag, " rd_out"}, {27'd0, rdo}, {27'd0, frd});
        check({tag, " busy at done"}, {31'd0, bdn}, 32'd0);
        check({tag, " cnt start"}, {27'd0, cnt0}, (elat == 26) ? 32'd25 : (elat == 25) ? 32'd24 : 32'd0);
    endtask

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] res, eres;
        logic [4:0]  rdo, cnt0;
        int          lat, bcyc, elat, edges;
        logic        b2b, bdn, seen;
        bit          rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{1'b0, 32'h40C00000, 32'h40000000, 5'd1,  32'h40400000, 26};
        tbl[1]  = '{1'b0, 32'h3F800000, 32'h40400000, 5'd2,  32'h3EAAAAAA, 26};
        tbl[2]  = '{1'b1, 32'h40800000, 32'h00000000, 5'd3,  32'h40000000, 25};
        tbl[3]  = '{1'b1, 32'h40000000, 32'h12345678, 5'd4,  32'h3FB504F3, 25};
        tbl[4]  = '{1'b1, 32'hBF800000, 32'h00000000, 5'd5,  32'h7FC00000, 0};
        tbl[5]  = '{1'b0, 32'h3F800000, 32'h00000000, 5'd7,  32'h7F800000, 0};
        tbl[6]  = '{1'b0, 32'h00000000, 32'h00000000, 5'd8,  32'h7FC00000, 0};
        tbl[7]  = '{1'b1, 32'h80000000, 32'h00000000, 5'd9,  32'h80000000, 0};
        tbl[8]  = '{1'b1, 32'h7F800000, 32'h00000000, 5'd10, 32'h7F800000, 0};
        tbl[9]  = '{1'b0, 32'h7F800000, 32'hBF800000, 5'd11, 32'hFF800000, 0};
        tbl[10] = '{1'b0, 32'h3F800000, 32'h7F800000, 5'd12, 32'h00000000, 0};
        tbl[11] = '{1'b0, 32'hC0000000, 32'h3F800000, 5'd13, 32'hC0000000, 26};
        tbl[12] = '{1'b0, 32'h7F000000, 32'h00800000, 5'd14, 32'h7F800000, 26};
        tbl[13] = '{1'b0, 32'h00800000, 32'h7F000000, 5'd15, 32'h00000000, 26};
        tbl[14] = '{1'b1, 32'h7FC00001, 32'h00000000, 5'd16, 32'h7FC00000, 0};

        clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        check("reset cnt",    {27'd0, cnt}, 32'd0);
        clr = 1'b0;

        for (int i = 0; i < 15; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].res, tbl[i].lat);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h40C00000; b = 32'h40000000; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'h40800000; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy-ignore cnt", {27'd0, cnt}, 32'd19);
        edges = 6; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                edges++;
            end
        end
        n_vec++;
        check("busy-ignore latency", edges, 26);
        check("busy-ignore result", result, 32'h40400000);
        check("busy-ignore rd_out", {27'd0, rd_out}, 32'd3);

        // back-to-back: second op issued in the done cycle of the first
        run_check("b2b first", 1'b0, 32'h3F800000, 32'h40400000, 5'd21, 32'h3EAAAAAA, 26);
        do_op(1'b1, 32'h40000000, 32'h0, 5'd22, res, rdo, lat, bcyc, cnt0, b2b, bdn);
        check("b2b issued in done cycle", {31'd0, b2b}, 32'd1);
        check("b2b second result", res, 32'h3FB504F3);
        check("b2b second latency", lat, 25);

        // clr mid-operation aborts with no done
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h40C00000; b = 32'h40000000; rd_in = 5'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("abort busy",   {31'd0, busy}, 32'd0);
        check("abort cnt",    {27'd0, cnt}, 32'd0);
        check("abort done",   {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", {27'd0, rd_out}, 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort no done", {31'd0, seen}, 32'd0);
        run_check("after abort sqrt4", 1'b1, 32'h40800000, 32'h0, 5'd7, 32'h40000000, 25);

        // clr together with start drops the start
        @(negedge clk);
        clr = 1'b1; start = 1'b1; op = 1'b0; a = 32'h40C00000; b = 32'h40000000;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        check("clr+start busy", {31'd0, busy}, 32'd0);
        check("clr+start done", {31'd0, done}, 32'd0);

        // random operands vs reference model
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) != 0) ra[30:23] = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 7) != 0) rb[30:23] = 8'($urandom_range(1, 254));
            if (rop && $urandom_range(0, 5) != 0) ra[31] = 1'b0;
            ref_model(rop, ra, rb, eres, elat);
            run_check($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)), eres, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fp_divsqrt_iter
`default_nettype wire
